// File: rtl/ysyx_23060191_mem_arbiter.sv
// Two-requester (IFU/LSU) round-robin arbiter and sequencer for the single
// data-memory port. One transaction is outstanding at a time. The winning
// request is registered, issued with a valid/ready handshake, and the single
// memory response is returned to the requester that owns the transaction.
module ysyx_23060191_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   // instruction-fetch requester
   input  logic                      ifu_req_valid,
   output logic                      ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     ifu_req_addr,
   output logic                      ifu_resp_valid,
   output logic [DATA_WIDTH-1:0]     ifu_resp_data,
   // load/store requester
   input  logic                      lsu_req_valid,
   output logic                      lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     lsu_req_addr,
   input  logic                      lsu_req_wen,
   input  logic [DATA_WIDTH-1:0]     lsu_req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   lsu_req_wmask,
   output logic                      lsu_resp_valid,
   output logic [DATA_WIDTH-1:0]     lsu_resp_data,
   // memory port
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [ADDR_WIDTH-1:0]     mem_req_addr,
   output logic                      mem_req_wen,
   output logic [DATA_WIDTH-1:0]     mem_req_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_req_wmask,
   input  logic                      mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_resp_data
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                  state_reg,     state_next;
   logic                    last_lsu_reg,  last_lsu_next;
   logic                    owner_lsu_reg, owner_lsu_next;
   logic [ADDR_WIDTH-1:0]   addr_reg,      addr_next;
   logic                    wen_reg,       wen_next;
   logic [DATA_WIDTH-1:0]   wdata_reg,     wdata_next;
   logic [MASK_WIDTH-1:0]   wmask_reg,     wmask_next;
   logic [DATA_WIDTH-1:0]   resp_data_reg, resp_data_next;

   // Round-robin: a lone requester always wins; on a tie the one not
   // granted last time wins (last_lsu resets to 1 so the IFU wins first).
   logic grant_ifu;
   logic grant_lsu;
   assign grant_ifu = ifu_req_valid & (~lsu_req_valid | last_lsu_reg);
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_reg);

   // Registered request fields and the response register drive the ports.
   assign mem_req_addr  = addr_reg;
   assign mem_req_wen   = wen_reg;
   assign mem_req_wdata = wdata_reg;
   assign mem_req_wmask = wmask_reg;
   assign ifu_resp_data = resp_data_reg;
   assign lsu_resp_data = resp_data_reg;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         last_lsu_reg  <= 1'b1;
         owner_lsu_reg <= 1'b0;
         addr_reg      <= '0;
         wen_reg       <= 1'b0;
         wdata_reg     <= '0;
         wmask_reg     <= '0;
         resp_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         last_lsu_reg  <= last_lsu_next;
         owner_lsu_reg <= owner_lsu_next;
         addr_reg      <= addr_next;
         wen_reg       <= wen_next;
         wdata_reg     <= wdata_next;
         wmask_reg     <= wmask_next;
         resp_data_reg <= resp_data_next;
      end
   end

   // Next-state, capture and handshake outputs; everything defaults to hold/0.
   always_comb begin
      state_next     = state_reg;
      last_lsu_next  = last_lsu_reg;
      owner_lsu_next = owner_lsu_reg;
      addr_next      = addr_reg;
      wen_next       = wen_reg;
      wdata_next     = wdata_reg;
      wmask_next     = wmask_reg;
      resp_data_next = resp_data_reg;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;

      case (state_reg)
         IDLE: begin
            if (grant_ifu) begin
               // Fetches are always plain reads with no data or mask.
               ifu_req_ready  = 1'b1;
               addr_next      = ifu_req_addr;
               wen_next       = 1'b0;
               wdata_next     = '0;
               wmask_next     = '0;
               owner_lsu_next = 1'b0;
               last_lsu_next  = 1'b0;
               state_next     = ISSUE;
            end else if (grant_lsu) begin
               lsu_req_ready  = 1'b1;
               addr_next      = lsu_req_addr;
               wen_next       = lsu_req_wen;
               wdata_next     = lsu_req_wdata;
               wmask_next     = lsu_req_wmask;
               owner_lsu_next = 1'b1;
               last_lsu_next  = 1'b1;
               state_next     = ISSUE;
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            // Only here is a memory response meaningful; elsewhere it is dropped.
            if (mem_resp_valid) begin
               resp_data_next = mem_resp_data;
               state_next     = RESP;
            end
         end
         RESP: begin
            ifu_resp_valid = ~owner_lsu_reg;
            lsu_resp_valid = owner_lsu_reg;
            state_next     = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter. Each task drives a scenario
// cycle by cycle and compares outputs against hand-computed values.
module tb_ysyx_23060191_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_data;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [31:0] lsu_req_wdata;
   logic [3:0]  lsu_req_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int vectors;
   int miscompares;

   ysyx_23060191_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_req_addr   (ifu_req_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_data  (ifu_resp_data),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_req_addr   (lsu_req_addr),
      .lsu_req_wen    (lsu_req_wen),
      .lsu_req_wdata  (lsu_req_wdata),
      .lsu_req_wmask  (lsu_req_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_data  (lsu_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      vectors++; if (ifu_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ifu_ready: got %b want 0", ifu_req_ready); end
      vectors++; if (lsu_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_lsu_ready: got %b want 0", lsu_req_ready); end
      vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_valid: got %b want 0", mem_req_valid); end
      vectors++; if (mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 0", mem_req_addr); end
      vectors++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      vectors++; if (ifu_resp_data !== 32'h0) begin miscompares++; $display("FAIL rst_resp_data: got %h want 0", ifu_resp_data); end
      $display("txn reset done");
      tick();
   endtask

   task automatic test_ifu_only();
      // cycle N: accept
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
      #1;
      vectors++; if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL ifu_ready_N: got %b want 1", ifu_req_ready); end
      vectors++; if (lsu_req_ready !== 1'b0) begin miscompares++; $display("FAIL ifu_lsu_ready_N: got %b want 0", lsu_req_ready); end
      tick();
      // N+1: issue
      ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      #1;
      vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL ifu_mem_valid_N1: got %b want 1", mem_req_valid); end
      vectors++; if (mem_req_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL ifu_mem_addr: got %h want 80000000", mem_req_addr); end
      vectors++; if ({mem_req_wen, mem_req_wmask} !== 5'b0) begin miscompares++; $display("FAIL ifu_mem_wen_mask: got %b want 00000", {mem_req_wen, mem_req_wmask}); end
      tick();
      // N+2: wait, memory answers
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0413;
      #1;
      vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL ifu_mem_valid_N2: got %b want 0", mem_req_valid); end
      tick();
      // N+3: response
      mem_resp_valid = 1'b0;
      #1;
      vectors++; if (ifu_resp_valid !== 1'b1) begin miscompares++; $display("FAIL ifu_resp_valid_N3: got %b want 1", ifu_resp_valid); end
      vectors++; if (ifu_resp_data !== 32'h0000_0413) begin miscompares++; $display("FAIL ifu_resp_data: got %h want 00000413", ifu_resp_data); end
      vectors++; if (lsu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL ifu_lsu_resp_valid: got %b want 0", lsu_resp_valid); end
      $display("txn ifu addr=%h data=%h", mem_req_addr, ifu_resp_data);
      tick();
      #1;
      vectors++; if (ifu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL ifu_resp_pulse: got %b want 0", ifu_resp_valid); end
   endtask

   task automatic test_lsu_store();
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1003; lsu_req_wen = 1'b1;
      lsu_req_wdata = 32'h0000_00AB; lsu_req_wmask = 4'b0001;
      #1;
      vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin miscompares++; $display("FAIL sb_ready: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
      tick();
      lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0; lsu_req_wen = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL sb_mem_valid: got %b want 1", mem_req_valid); end
      vectors++; if (mem_req_addr !== 32'h8000_1003) begin miscompares++; $display("FAIL sb_mem_addr: got %h want 80001003", mem_req_addr); end
      vectors++; if (mem_req_wen !== 1'b1) begin miscompares++; $display("FAIL sb_mem_wen: got %b want 1", mem_req_wen); end
      vectors++; if (mem_req_wdata !== 32'h0000_00AB) begin miscompares++; $display("FAIL sb_mem_wdata: got %h want 000000ab", mem_req_wdata); end
      vectors++; if (mem_req_wmask !== 4'b0001) begin miscompares++; $display("FAIL sb_mem_wmask: got %b want 0001", mem_req_wmask); end
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0;
      #1;
      vectors++; if (lsu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL sb_resp_early: got %b want 0", lsu_resp_valid); end
      tick();
      mem_resp_valid = 1'b0;
      #1;
      vectors++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b01) begin miscompares++; $display("FAIL sb_resp_valid: got %b want 01", {ifu_resp_valid, lsu_resp_valid}); end
      $display("txn lsu store addr=%h wdata=%h", mem_req_addr, mem_req_wdata);
      tick();
      #1;
      vectors++; if (lsu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL sb_resp_pulse: got %b want 0", lsu_resp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data;
      logic        exp_ifu_g, exp_lsu_g, exp_ifu_r, exp_lsu_r, lsu_turn;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_A000;
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_B000; lsu_req_wen = 1'b0;
      lsu_req_wdata = 32'h0; lsu_req_wmask = 4'hF;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         mem_resp_data = 32'hD000_0000 + 32'(c);
         #1;
         lsu_turn  = ((c / 4) % 2) == 1;
         exp_ifu_g = (c % 4 == 0) && !lsu_turn;
         exp_lsu_g = (c % 4 == 0) && lsu_turn;
         exp_ifu_r = (c % 4 == 3) && !lsu_turn;
         exp_lsu_r = (c % 4 == 3) && lsu_turn;
         vectors++; if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu_g, exp_lsu_g}) begin miscompares++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, {ifu_req_ready, lsu_req_ready}, {exp_ifu_g, exp_lsu_g}); end
         vectors++; if ({ifu_resp_valid, lsu_resp_valid} !== {exp_ifu_r, exp_lsu_r}) begin miscompares++; $display("FAIL b2b_resp c=%0d: got %b want %b", c, {ifu_resp_valid, lsu_resp_valid}, {exp_ifu_r, exp_lsu_r}); end
         if (c % 4 == 1) begin
            vectors++; if (mem_req_addr !== (lsu_turn ? 32'h0000_B000 : 32'h0000_A000)) begin miscompares++; $display("FAIL b2b_addr c=%0d: got %h want %h", c, mem_req_addr, lsu_turn ? 32'h0000_B000 : 32'h0000_A000); end
         end
         if (c % 4 == 3) begin
            exp_data = 32'hD000_0000 + 32'(c) - 32'd1;
            vectors++; if (ifu_resp_data !== exp_data) begin miscompares++; $display("FAIL b2b_data c=%0d: got %h want %h", c, ifu_resp_data, exp_data); end
            $display("txn b2b owner=%s data=%h", lsu_turn ? "lsu" : "ifu", ifu_resp_data);
         end
         tick();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
   endtask

   task automatic test_stall();
      // last grant was LSU, so IFU wins this tie
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0800;
      #1;
      vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin miscompares++; $display("FAIL stall_grant: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
      tick();
      ifu_req_addr = 32'h8000_0044;
      for (int s = 0; s < 4; s++) begin
         mem_req_ready = (s == 3);
         #1;
         vectors++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0040}) begin miscompares++; $display("FAIL stall_req s=%0d: got %b/%h want 1/80000040", s, mem_req_valid, mem_req_addr); end
         vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin miscompares++; $display("FAIL stall_ready s=%0d: got %b want 00", s, {ifu_req_ready, lsu_req_ready}); end
         tick();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_1234;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      vectors++; if ({ifu_resp_valid, lsu_resp_valid, ifu_resp_data} !== {2'b10, 32'h0000_1234}) begin miscompares++; $display("FAIL stall_resp: got %b%b/%h want 10/00001234", ifu_resp_valid, lsu_resp_valid, ifu_resp_data); end
      $display("txn stalled ifu addr=%h data=%h", mem_req_addr, ifu_resp_data);
      tick();
   endtask

   task automatic test_late_resp();
      // spurious responses while idle
      mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
      for (int s = 0; s < 3; s++) begin
         if (s == 2) mem_resp_valid = 1'b0;
         #1;
         vectors++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL spurious s=%0d: got %b want 00", s, {ifu_resp_valid, lsu_resp_valid}); end
         tick();
      end
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1'b0; lsu_req_wmask = 4'hF;
      #1;
      vectors++; if (lsu_req_ready !== 1'b1) begin miscompares++; $display("FAIL late_grant: got %b want 1", lsu_req_ready); end
      tick();
      lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         #1;
         vectors++; if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin miscompares++; $display("FAIL late_wait s=%0d: got %b want 000", s, {mem_req_valid, ifu_resp_valid, lsu_resp_valid}); end
         tick();
      end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_CAFE;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      vectors++; if ({lsu_resp_valid, lsu_resp_data} !== {1'b1, 32'h0000_CAFE}) begin miscompares++; $display("FAIL late_resp: got %b/%h want 1/0000cafe", lsu_resp_valid, lsu_resp_data); end
      $display("txn late lsu load data=%h", lsu_resp_data);
      tick();
   endtask

   task automatic test_reset_mid();
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0080;
      tick();
      ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      // now in WAIT: reset before any response
      mem_req_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD;
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
      #1;
      vectors++; if (ifu_req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_grant: got %b want 1", ifu_req_ready); end
      vectors++; if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin miscompares++; $display("FAIL rmid_outputs: got %b want 000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}); end
      vectors++; if (mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_addr_cleared: got %h want 0", mem_req_addr); end
      tick();
      ifu_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
      #1;
      vectors++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0100}) begin miscompares++; $display("FAIL rmid_issue: got %b/%h want 1/80000100", mem_req_valid, mem_req_addr); end
      vectors++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL rmid_no_resp: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0077;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      vectors++; if ({ifu_resp_valid, ifu_resp_data} !== {1'b1, 32'h0000_0077}) begin miscompares++; $display("FAIL rmid_resp: got %b/%h want 1/00000077", ifu_resp_valid, ifu_resp_data); end
      $display("txn post-reset ifu data=%h", ifu_resp_data);
      tick();
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
      lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
      lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      #2;
      test_reset();
      test_ifu_only();
      test_lsu_store();
      test_back_to_back();
      test_stall();
      test_late_resp();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
